// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the 6502 program-counter sequencer.
package pc_seq_pkg;

  localparam int PC_W = 8;

  typedef enum logic [1:0] {
    CMD_INC    = 2'd0,
    CMD_JMP    = 2'd1,
    CMD_BRANCH = 2'd2,
    CMD_NOP    = 2'd3
  } pc_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_FIN
  } pc_seq_state_t;

endpackage

// File: rtl/pc_seq_byte_add.sv
// 8-bit PC byte adder with a two's-complement addend; flags a 6502 page crossing.
module pc_seq_byte_add
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0] value,
  input  logic [PC_W-1:0] addend,
  output logic [PC_W-1:0] sum,
  output logic            carry_out,
  output logic            page_cross
);

  assign {carry_out, sum} = {1'b0, value} + {1'b0, addend};

  // A negative addend normally carries out; the page moves only when the
  // carry disagrees with the sign of the addend.
  assign page_cross = carry_out ^ addend[PC_W-1];

endmodule

// File: rtl/pc_sequencer.sv
// Sequences PCL/PCH load strobes for INC/JMP/BRANCH with 6502 page-carry fix-up.
// Optional: define PC_SEQ_PAGE_STAT_EN to add a saturating page_cross_count output.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [PC_W-1:0]   operand_lo,
  input  logic [PC_W-1:0]   operand_hi,
  input  logic [PC_W-1:0]   pcl_cur,
  input  logic [PC_W-1:0]   pch_cur,
  output logic [PC_W-1:0]   pcl_data,
  output logic              pcl_load,
  output logic [PC_W-1:0]   pch_data,
  output logic              pch_load,
  output logic              done,
  output logic              page_cross,
  output logic [15:0]       pc_shadow
`ifdef PC_SEQ_PAGE_STAT_EN
  , output logic [15:0]     page_cross_count
`endif
);

  pc_seq_state_t   state_q, state_d;
  pc_cmd_t         cmd_in;
  logic            accept;
  logic [PC_W-1:0] pch_q;
  logic            neg_q;
  logic            cross_q;

  logic [PC_W-1:0] add_value, add_addend, add_sum;
  logic            add_carry, add_cross, lo_cross;

  logic [PC_W-1:0] pcl_data_d, pch_data_d;
  logic            pcl_load_d, pch_load_d, done_d, page_cross_d;

  assign cmd_in    = pc_cmd_t'(cmd);
  assign cmd_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign accept    = cmd_valid && cmd_ready;

  // One adder serves both bytes: live PCL at acceptance, captured PCH in LOW.
  always_comb begin
    add_value  = pcl_cur;
    add_addend = (cmd_in == CMD_INC) ? 8'h01 : operand_lo;
    if (state_q == ST_LOW) begin
      add_value  = pch_q;
      add_addend = neg_q ? 8'hFF : 8'h01;
    end
  end

  pc_seq_byte_add u_add (
    .value      (add_value),
    .addend     (add_addend),
    .sum        (add_sum),
    .carry_out  (add_carry),
    .page_cross (add_cross)
  );

  assign lo_cross = (cmd_in == CMD_INC) ? add_carry : add_cross;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    pcl_data_d   = pcl_data;
    pch_data_d   = pch_data;
    pcl_load_d   = 1'b0;
    pch_load_d   = 1'b0;
    done_d       = 1'b0;
    page_cross_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept) begin
          state_d = ST_LOW;
          case (cmd_in)
            CMD_INC, CMD_BRANCH: begin
              pcl_data_d = add_sum;
              pcl_load_d = 1'b1;
              done_d     = !lo_cross;
            end
            CMD_JMP: begin
              pcl_data_d = operand_lo;
              pch_data_d = operand_hi;
              pcl_load_d = 1'b1;
              pch_load_d = 1'b1;
              done_d     = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        if (cross_q) begin
          state_d      = ST_HIGH;
          pch_data_d   = add_sum;
          pch_load_d   = 1'b1;
          page_cross_d = 1'b1;
          done_d       = 1'b1;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_HIGH: state_d = ST_FIN;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pch_q   <= '0;
      neg_q   <= 1'b0;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pch_q   <= pch_cur;
        neg_q   <= (cmd_in == CMD_BRANCH) && operand_lo[PC_W-1];
        cross_q <= ((cmd_in == CMD_INC) || (cmd_in == CMD_BRANCH)) && lo_cross;
      end
    end
  end

  // Strobes are registered so the PC registers see glitch-free single-clk pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcl_data   <= '0;
      pch_data   <= '0;
      pcl_load   <= 1'b0;
      pch_load   <= 1'b0;
      done       <= 1'b0;
      page_cross <= 1'b0;
      pc_shadow  <= RESET_PC;
    end else begin
      pcl_data   <= pcl_data_d;
      pch_data   <= pch_data_d;
      pcl_load   <= pcl_load_d;
      pch_load   <= pch_load_d;
      done       <= done_d;
      page_cross <= page_cross_d;
      if (pcl_load_d || pch_load_d)
        pc_shadow <= {pch_data_d, pcl_data_d};
    end
  end

`ifdef PC_SEQ_PAGE_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      page_cross_count <= '0;
    else if (page_cross && (page_cross_count != 16'hFFFF))
      page_cross_count <= page_cross_count + 16'd1;
  end
`endif

endmodule
